vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing generator with pixel-source latency realignment.
// Latency : colour/sync on pins PIPE_LAT+1 clk after the request; strobes 1 clk after the pix_ce edge.
// Backpress: none; free-running raster, the pixel source must answer exactly PIPE_LAT clk after a request.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_ce                   one-clk pulse on which the raster position advances
//   read, read_h, read_v     request to the pixel source (column/line, 0 outside active area)
//   pixel_rgb                {R[2:0],G[2:0],B[1:0]} returned PIPE_LAT clk after the request
//   line_start, frame_end    one-clk strobes (start of active line / after last active pixel)
//   HSYNC, VSYNC             syncs with polarity applied, aligned to colour
//   VGAR, VGAG, VGAB         colour pins, 0 outside the active area
// Optional: define TEST_PATTERN_EN to add input test_pat (8x8 checkerboard replaces pixel_rgb).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 400,
  parameter int V_FRONT   = 12,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 35,
  parameter int CLK_DIV   = 2,
  parameter int PIPE_LAT  = 1,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int H_W       = 10,
  parameter int V_W       = 9
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pix_ce,
  output logic           read,
  output logic [H_W-1:0] read_h,
  output logic [V_W-1:0] read_v,
  input  logic [7:0]     pixel_rgb,
`ifdef TEST_PATTERN_EN
  input  logic           test_pat,
`endif
  output logic           line_start,
  output logic           frame_end,
  output logic           HSYNC,
  output logic           VSYNC,
  output logic [2:0]     VGAR,
  output logic [2:0]     VGAG,
  output logic [1:0]     VGAB
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0]   V_ACT_LAST = V_W'(V_ACTIVE - 1);

  // One extra bit so window ends equal to 2**W still compare correctly.
  localparam logic [H_W:0] H_ACT_X = (H_W+1)'(H_ACTIVE);
  localparam logic [H_W:0] H_SS_X  = (H_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [H_W:0] H_SE_X  = (H_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W:0] V_ACT_X = (V_W+1)'(V_ACTIVE);
  localparam logic [V_W:0] V_SS_X  = (V_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [V_W:0] V_SE_X  = (V_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  // Elaboration-time parameter sanity
  if (H_TOTAL > (1 << H_W)) begin : g_chk_h
    $error("vga_timing_gen: H_TOTAL does not fit in H_W bits");
  end
  if (V_TOTAL > (1 << V_W)) begin : g_chk_v
    $error("vga_timing_gen: V_TOTAL does not fit in V_W bits");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_chk_lat
    $error("vga_timing_gen: PIPE_LAT must be 0..7");
  end

  typedef struct packed {
    logic rd;
    logic hs;
    logic vs;
`ifdef TEST_PATTERN_EN
    logic pat;
`endif
  } tap_t;

  logic [DIV_W-1:0] r_div;
  logic             r_pix_ce;
  logic [H_W-1:0]   r_pos_h;
  logic [V_W-1:0]   r_pos_v;
  logic             r_line_start;
  logic             r_frame_end;
  logic             r_hsync;
  logic             r_vsync;
  logic [7:0]       r_rgb;

  logic [DIV_W-1:0] w_div_nxt;
  logic             w_h_last;
  logic             w_v_last;
  logic [H_W-1:0]   w_nxt_h;
  logic [V_W-1:0]   w_nxt_v;
  logic             w_read;
  tap_t             w_cur;
  tap_t             w_tap;
  logic [7:0]       w_rgb_src;

  // ---------------- divider and raster counters ----------------
  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
  assign w_h_last  = (r_pos_h == H_LAST);
  assign w_v_last  = (r_pos_v == V_LAST);
  assign w_nxt_h   = w_h_last ? '0 : r_pos_h + H_W'(1);
  assign w_nxt_v   = w_h_last ? (w_v_last ? '0 : r_pos_v + V_W'(1)) : r_pos_v;

  // pix_ce is registered from the next divider value so it is 0 while in
  // reset even when CLK_DIV=1 (div_cnt==CLK_DIV-1 holds trivially there).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div        <= '0;
      r_pix_ce     <= 1'b0;
      r_pos_h      <= '0;
      r_pos_v      <= '0;
      r_line_start <= 1'b0;
      r_frame_end  <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_pix_ce     <= (w_div_nxt == DIV_LAST);
      r_line_start <= r_pix_ce && (w_nxt_h == '0) && ({1'b0, w_nxt_v} < V_ACT_X);
      r_frame_end  <= r_pix_ce && (r_pos_h == H_ACT_LAST) && (r_pos_v == V_ACT_LAST);
      if (r_pix_ce) begin
        r_pos_h <= w_nxt_h;
        r_pos_v <= w_nxt_v;
      end
    end
  end

  // ---------------- request side ----------------
  assign w_read = ({1'b0, r_pos_h} < H_ACT_X) && ({1'b0, r_pos_v} < V_ACT_X);

`ifdef TEST_PATTERN_EN
  // Zero-extended so bit 3 exists even for very narrow counters.
  logic [H_W+3:0] w_h_ext;
  logic [V_W+3:0] w_v_ext;
  assign w_h_ext = {4'b0, read_h};
  assign w_v_ext = {4'b0, read_v};
`endif

  always_comb begin
    w_cur    = '0;
    w_cur.rd = w_read;
    w_cur.hs = ({1'b0, r_pos_h} >= H_SS_X) && ({1'b0, r_pos_h} < H_SE_X);
    w_cur.vs = ({1'b0, r_pos_v} >= V_SS_X) && ({1'b0, r_pos_v} < V_SE_X);
`ifdef TEST_PATTERN_EN
    w_cur.pat = w_h_ext[3] ^ w_v_ext[3];
`endif
  end

  // ---------------- alignment delay line ----------------
  // PIPE_LAT stages here plus the pin register below give PIPE_LAT+1 clk,
  // so the tap lines up with pixel_rgb for the same request.
  if (PIPE_LAT == 0) begin : g_nodly
    assign w_tap = w_cur;
  end else begin : g_dly
    tap_t r_dly [PIPE_LAT];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE_LAT; i++) r_dly[i] <= '0;
      end else begin
        r_dly[0] <= w_cur;
        for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_tap = r_dly[PIPE_LAT-1];
  end

  // ---------------- pin stage ----------------
  always_comb begin
    w_rgb_src = pixel_rgb;
`ifdef TEST_PATTERN_EN
    if (test_pat) w_rgb_src = w_tap.pat ? 8'hFF : 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= ~HS_ON;
      r_vsync <= ~VS_ON;
      r_rgb   <= 8'h00;
    end else begin
      r_hsync <= w_tap.hs ? HS_ON : ~HS_ON;
      r_vsync <= w_tap.vs ? VS_ON : ~VS_ON;
      r_rgb   <= w_tap.rd ? w_rgb_src : 8'h00;
    end
  end

  assign pix_ce     = r_pix_ce;
  assign read       = w_read;
  assign read_h     = w_read ? r_pos_h : '0;
  assign read_v     = w_read ? r_pos_v : '0;
  assign line_start = r_line_start;
  assign frame_end  = r_frame_end;
  assign HSYNC      = r_hsync;
  assign VSYNC      = r_vsync;
  assign VGAR       = r_rgb[7:5];
  assign VGAG       = r_rgb[4:2];
  assign VGAB       = r_rgb[1:0];

endmodule
